// File: rtl/heap_pkg.sv
// heap_pkg: shared op codes, FSM states and leds layout for the heap command engine
package heap_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_TOP, OP_SIZE} op_e;
  typedef enum logic [2:0] {IDLE, PUSH_WR, SIFT_UP, POP_MV, SIFT_DN, DONE} state_e;
  localparam int LED_BUSY = 0;
  localparam int LED_EMPTY = 1;
  localparam int LED_FULL = 2;
  localparam int LED_ERR = 3;
  function automatic logic [3:0] op_onehot(input op_e op);
    return 4'b0001 << op;
  endfunction
endpackage

// File: rtl/heap_cmd_engine_btn_edge_sync.sv
// btn_edge_sync: two-flop synchroniser plus one-cycle rising-edge pulse per input bit
module btn_edge_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);
  logic [N-1:0] s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/heap_cmd_engine.sv
// heap_cmd_engine: button-driven PUSH/POP/TOP/SIZE on a register-array binary min-heap
module heap_cmd_engine
  import heap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btns,
  input  logic [DATA_W-1:0] switches,
  output logic [7:0]        leds,
  output logic [DATA_W-1:0] disp
);
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH);
  state_e state_q, state_d;
  logic [DATA_W-1:0] heap_q [DEPTH];
  logic [DATA_W-1:0] heap_d [DEPTH];
  logic [ADDR_W:0] count_q, count_d, cm1;
  logic [ADDR_W-1:0] idx_q, idx_d, par;
  logic [DATA_W-1:0] disp_q, disp_d, key_q, key_d;
  logic err_q, err_d, empty_q, full_q;
  logic [3:0] op_q, op_d, rise;
  logic [ADDR_W+1:0] lc, rc, cc;
  logic l_ok, r_ok;

  btn_edge_sync #(.N(4)) u_sync (.clk(clk), .reset(reset), .din(btns), .rise(rise));

  // child indices are two bits wider than idx so 2i+2 never wraps
  always_comb begin
    par = (idx_q - ADDR_W'(1)) >> 1;
    lc = {1'b0, idx_q, 1'b1};
    rc = lc + (ADDR_W+2)'(1);
    l_ok = lc < {1'b0, count_q};
    r_ok = rc < {1'b0, count_q};
    cc = (r_ok && heap_q[rc[ADDR_W-1:0]] < heap_q[lc[ADDR_W-1:0]]) ? rc : lc;
    cm1 = count_q - (ADDR_W+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    heap_d = heap_q;
    count_d = count_q;
    idx_d = idx_q;
    disp_d = disp_q;
    key_d = key_q;
    err_d = err_q;
    op_d = op_q;
    case (state_q)
      IDLE: begin
        if (rise[OP_PUSH]) begin
          op_d = op_onehot(OP_PUSH);
          err_d = count_q == CAP;
          key_d = switches;
          state_d = (count_q == CAP) ? IDLE : PUSH_WR;
        end else if (rise[OP_POP]) begin
          op_d = op_onehot(OP_POP);
          err_d = count_q == '0;
          state_d = (count_q == '0) ? IDLE : POP_MV;
        end else if (rise[OP_TOP]) begin
          op_d = op_onehot(OP_TOP);
          err_d = count_q == '0;
          disp_d = (count_q == '0) ? disp_q : heap_q[0];
        end else if (rise[OP_SIZE]) begin
          op_d = op_onehot(OP_SIZE);
          err_d = 1'b0;
          disp_d = DATA_W'(count_q);
        end
      end
      PUSH_WR: begin
        heap_d[count_q[ADDR_W-1:0]] = key_q;
        idx_d = count_q[ADDR_W-1:0];
        count_d = count_q + (ADDR_W+1)'(1);
        disp_d = key_q;
        state_d = SIFT_UP;
      end
      SIFT_UP: begin
        if (idx_q != '0 && heap_q[idx_q] < heap_q[par]) begin
          heap_d[idx_q] = heap_q[par];
          heap_d[par] = heap_q[idx_q];
          idx_d = par;
        end else state_d = DONE;
      end
      POP_MV: begin
        disp_d = heap_q[0];
        heap_d[0] = heap_q[cm1[ADDR_W-1:0]];
        count_d = cm1;
        idx_d = '0;
        state_d = SIFT_DN;
      end
      SIFT_DN: begin
        if (l_ok && heap_q[cc[ADDR_W-1:0]] < heap_q[idx_q]) begin
          heap_d[idx_q] = heap_q[cc[ADDR_W-1:0]];
          heap_d[cc[ADDR_W-1:0]] = heap_q[idx_q];
          idx_d = cc[ADDR_W-1:0];
        end else state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      heap_q <= '{default: '0};
      count_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      key_q <= '0;
      err_q <= 1'b0;
      op_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      heap_q <= heap_d;
      count_q <= count_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      key_q <= key_d;
      err_q <= err_d;
      op_q <= op_d;
      empty_q <= count_q == '0;
      full_q <= count_q == CAP;
    end
  end

  assign leds = {op_q, err_q, full_q, empty_q, state_q != IDLE};
  assign disp = disp_q;
endmodule

// File: tb/tb_heap_cmd_engine.sv
// tb_heap_cmd_engine: directed button sequences against hand-computed disp/leds values
module tb_heap_cmd_engine;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] btns = '0;
  logic [7:0] switches = '0;
  logic [7:0] leds, disp;
  int checks = 0;
  int errs = 0;
  logic busy_prev = 1'b0;

  heap_cmd_engine dut (.clk(clk), .reset(reset), .btns(btns), .switches(switches), .leds(leds), .disp(disp));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] mask, input logic [7:0] key);
    int n;
    @(negedge clk);
    switches = key;
    btns = mask;
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    while (leds[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_len", n <= 7, 1);
    btns = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int bad;
    if (busy_prev && !leds[0]) begin
      bad = 0;
      for (int i = 1; i < DEPTH; i++)
        if (i < int'(dut.count_q) && dut.heap_q[(i-1)/2] > dut.heap_q[i]) bad++;
      chk("heap_prop", bad, 0);
    end
    busy_prev = leds[0];
  end

  initial begin
    logic [7:0] exp1 [8];
    logic [3:0] ops1 [8];
    logic [7:0] keys1 [8];
    exp1 = '{8'h00, 8'h07, 8'h04, 8'h02, 8'h04, 8'h04, 8'h01, 8'h07};
    ops1 = '{4'h8, 4'h1, 4'h1, 4'h8, 4'h4, 4'h2, 4'h8, 4'h4};
    keys1 = '{8'h00, 8'h07, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp", disp, 8'h00);
    chk("rst_leds", leds, 8'h02);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(ops1[i], keys1[i]);
      chk("t1_disp", disp, exp1[i]);
      chk("t1_err", leds[3], 1'b0);
      chk("t1_op", leds[7:4], ops1[i]);
    end

    do_op(4'h2, 8'h00);
    chk("t2_pop_last", disp, 8'h07);
    do_op(4'h2, 8'h00);
    chk("t2_pop_err", leds[3], 1'b1);
    chk("t2_pop_disp", disp, 8'h07);
    chk("t2_empty", leds[1], 1'b1);
    do_op(4'h4, 8'h00);
    chk("t2_top_err", leds[3], 1'b1);
    chk("t2_top_disp", disp, 8'h07);
    do_op(4'h8, 8'h00);
    chk("t2_size_err", leds[3], 1'b0);
    chk("t2_size", disp, 8'h00);

    for (int k = 0; k < 16; k++) begin
      do_op(4'h1, 8'(8'hF0 - k));
      chk("t3_push_disp", disp, 8'hF0 - k);
    end
    do_op(4'h1, 8'h00);
    chk("t3_full_err", leds[3], 1'b1);
    chk("t3_full", leds[2], 1'b1);
    chk("t3_full_disp", disp, 8'hE1);
    do_op(4'h8, 8'h00);
    chk("t3_size", disp, 8'h10);
    for (int k = 0; k < 16; k++) begin
      do_op(4'h2, 8'h00);
      chk("t3_pop", disp, 8'hE1 + k);
    end
    chk("t3_empty", leds[1], 1'b1);
    chk("t3_notfull", leds[2], 1'b0);

    do_op(4'h1, 8'h05);
    do_op(4'h1, 8'h05);
    do_op(4'h1, 8'h03);
    do_op(4'h1, 8'h05);
    do_op(4'h2, 8'h00);
    chk("t4_pop0", disp, 8'h03);
    for (int k = 0; k < 3; k++) begin
      do_op(4'h2, 8'h00);
      chk("t4_pop", disp, 8'h05);
    end
    chk("t4_empty", leds[1], 1'b1);

    do_op(4'h1, 8'h09);
    do_op(4'h1, 8'h02);
    do_op(4'h1, 8'h05);
    do_op(4'h6, 8'h00);
    chk("t5_prio_disp", disp, 8'h02);
    chk("t5_prio_op", leds[7:4], 4'b0010);
    @(negedge clk) btns = 4'b0010;
    @(negedge clk) btns = 4'b0011;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_idle", leds[0], 1'b0);
    btns = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_busy_pop", disp, 8'h05);
    chk("t5_busy_op", leds[7:4], 4'b0010);
    do_op(4'h8, 8'h00);
    chk("t5_size", disp, 8'h01);

    foreach (keys1[i]) keys1[i] = 8'h10 * (i + 1);
    for (int i = 0; i < 8; i++) do_op(4'h1, keys1[7-i]);
    do_op(4'h8, 8'h00);
    chk("t6_size9", disp, 8'h09);
    @(negedge clk) btns = 4'b0010;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_busy", leds[0], 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_disp", disp, 8'h00);
    chk("t6_rst_leds", leds, 8'h02);
    btns = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    do_op(4'h8, 8'h00);
    chk("t6_size", disp, 8'h00);
    chk("t6_err", leds[3], 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
